// File: rtl/alarm_core_multi.sv
// Multi-alarm clock core: timekeeping, time/alarm editing, and a ring/snooze sound FSM.
// Edits and ticks update working registers; hours/mins are registered from the next-cycle values.
module alarm_core_multi #(
  parameter int unsigned N_ALARMS      = 4,
  parameter int unsigned TICKS_PER_MIN = 60,
  parameter int unsigned SNOOZE_MIN    = 5,
  parameter int unsigned RING_MIN      = 10
) (
  input  logic                Clk,
  input  logic                Clr,
  input  logic                Tick,
  input  logic                SetTime,
  input  logic                SetAlarm,
  input  logic                Next,
  input  logic                Up,
  input  logic                Snooze,
  input  logic                Stop,
  input  logic                Mute,
  input  logic [2:0]          Sel,
  output logic [4:0]          hours,
  output logic [5:0]          mins,
  output logic [2:0]          day,
  output logic [N_ALARMS-1:0] alarm_en,
  output logic [2:0]          active_alarm,
  output logic                sound,
  output logic                dblink,
  output logic                snoozing
);

  localparam int unsigned SEC_W   = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SLOTS   = 8;

  typedef enum logic [1:0] {M_RUN, M_SET_TIME, M_SET_ALARM} mode_t;
  typedef enum logic [1:0] {F_HOUR, F_MIN, F_AUX} field_t;
  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZED} snd_t;

  mode_t             mode, mode_n;
  field_t            field, field_n;
  snd_t              snd;
  logic [2:0]        sel, sel_n;
  logic [SEC_W-1:0]  sec, sec_n;
  logic [4:0]        t_hour, hour_n;
  logic [5:0]        t_min, min_n;
  logic [2:0]        t_day, day_n;
  logic [4:0]        al_hour   [SLOTS];
  logic [5:0]        al_min    [SLOTS];
  logic [4:0]        al_hour_n [SLOTS];
  logic [5:0]        al_min_n  [SLOTS];
  logic [N_ALARMS-1:0] al_en, en_n;
  logic [4:0]        disp_hour_n;
  logic [5:0]        disp_min_n;
  logic              wrap_c;
  logic              min_evt;
  logic              hit;
  logic [2:0]        hit_idx;
  logic [CNT_W-1:0]  ring_cnt, snz_cnt;

  assign day      = t_day;
  assign alarm_en = al_en;

  function automatic field_t next_field(input field_t f);
    case (f)
      F_HOUR:  next_field = F_MIN;
      F_MIN:   next_field = F_AUX;
      default: next_field = F_HOUR;
    endcase
  endfunction

  function automatic logic [4:0] inc_hour(input logic [4:0] h);
    inc_hour = (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_min(input logic [5:0] m);
    inc_min = (m == 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  // Mode FSM next state plus timekeeping and edit datapath
  always_comb begin
    mode_n    = mode;
    field_n   = field;
    sel_n     = sel;
    sec_n     = sec;
    hour_n    = t_hour;
    min_n     = t_min;
    day_n     = t_day;
    al_hour_n = al_hour;
    al_min_n  = al_min;
    en_n      = al_en;
    wrap_c    = 1'b0;
    case (mode)
      M_RUN: begin
        if (Tick) begin
          if (sec == SEC_W'(TICKS_PER_MIN - 1)) begin
            sec_n  = '0;
            wrap_c = 1'b1;
            min_n  = inc_min(t_min);
            if (t_min == 6'd59) begin
              hour_n = inc_hour(t_hour);
              if (t_hour == 5'd23) begin
                day_n = (t_day == 3'd6) ? 3'd0 : t_day + 3'd1;
              end
            end
          end else begin
            sec_n = sec + SEC_W'(1);
          end
        end
        if (SetTime) begin
          mode_n  = M_SET_TIME;
          field_n = F_HOUR;
        end else if (SetAlarm && (4'(Sel) < 4'(N_ALARMS))) begin
          mode_n  = M_SET_ALARM;
          field_n = F_HOUR;
          sel_n   = Sel;
        end
      end
      M_SET_TIME: begin
        if (SetTime) begin
          mode_n = M_RUN;
          sec_n  = '0;
        end else begin
          if (Up) begin
            case (field)
              F_HOUR:  hour_n = inc_hour(t_hour);
              F_MIN:   min_n  = inc_min(t_min);
              default: day_n  = (t_day == 3'd6) ? 3'd0 : t_day + 3'd1;
            endcase
          end
          if (Next) field_n = next_field(field);
        end
      end
      M_SET_ALARM: begin
        if (SetAlarm) begin
          mode_n = M_RUN;
        end else begin
          if (Up) begin
            case (field)
              F_HOUR:  al_hour_n[sel] = inc_hour(al_hour[sel]);
              F_MIN:   al_min_n[sel]  = inc_min(al_min[sel]);
              default: en_n = al_en ^ (N_ALARMS'(1) << sel);
            endcase
          end
          if (Next) field_n = next_field(field);
        end
      end
      default: mode_n = M_RUN;
    endcase
    disp_hour_n = (mode_n == M_SET_ALARM) ? al_hour_n[sel_n] : hour_n;
    disp_min_n  = (mode_n == M_SET_ALARM) ? al_min_n[sel_n]  : min_n;
  end

  // Lowest enabled alarm whose hour/minute equals the current time
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < int'(N_ALARMS); k++) begin
      if (!hit && al_en[k] && (al_hour[k] == t_hour) && (al_min[k] == t_min)) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      mode    <= M_RUN;
      field   <= F_HOUR;
      sel     <= '0;
      sec     <= '0;
      t_hour  <= '0;
      t_min   <= '0;
      t_day   <= '0;
      al_en   <= '0;
      for (int k = 0; k < int'(SLOTS); k++) begin
        al_hour[k] <= '0;
        al_min[k]  <= '0;
      end
      min_evt <= 1'b0;
      hours   <= '0;
      mins    <= '0;
      dblink  <= 1'b0;
    end else begin
      mode    <= mode_n;
      field   <= field_n;
      sel     <= sel_n;
      sec     <= sec_n;
      t_hour  <= hour_n;
      t_min   <= min_n;
      t_day   <= day_n;
      al_en   <= en_n;
      al_hour <= al_hour_n;
      al_min  <= al_min_n;
      min_evt <= wrap_c;
      hours   <= disp_hour_n;
      mins    <= disp_min_n;
      dblink  <= (mode_n != M_RUN);
    end
  end

  // Sound FSM; sound/snoozing follow the state one cycle later
  always_ff @(posedge Clk) begin
    if (Clr) begin
      snd          <= S_IDLE;
      ring_cnt     <= '0;
      snz_cnt      <= '0;
      active_alarm <= '0;
      sound        <= 1'b0;
      snoozing     <= 1'b0;
    end else begin
      sound    <= (snd == S_RING) && !Mute;
      snoozing <= (snd == S_SNOOZED);
      case (snd)
        S_IDLE: begin
          if (min_evt && hit) begin
            snd          <= S_RING;
            active_alarm <= hit_idx;
            ring_cnt     <= CNT_W'(RING_MIN);
          end
        end
        S_RING: begin
          if (Stop) begin
            snd <= S_IDLE;
          end else if (Snooze) begin
            snd     <= S_SNOOZED;
            snz_cnt <= CNT_W'(SNOOZE_MIN);
          end else if (min_evt) begin
            if (ring_cnt <= CNT_W'(1)) begin
              snd      <= S_IDLE;
              ring_cnt <= '0;
            end else begin
              ring_cnt <= ring_cnt - CNT_W'(1);
            end
          end
        end
        S_SNOOZED: begin
          if (Stop) begin
            snd <= S_IDLE;
          end else if (min_evt) begin
            if (snz_cnt <= CNT_W'(1)) begin
              snd      <= S_RING;
              snz_cnt  <= '0;
              ring_cnt <= CNT_W'(RING_MIN);
            end else begin
              snz_cnt <= snz_cnt - CNT_W'(1);
            end
          end
        end
        default: snd <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_core_multi.sv
// Directed bench for alarm_core_multi with short minutes, snooze and ring timeout.
module tb_alarm_core_multi;

  localparam int unsigned N = 4;

  logic         Clk = 1'b0;
  logic         Clr = 1'b1;
  logic         Tick = 1'b0, SetTime = 1'b0, SetAlarm = 1'b0, Next = 1'b0, Up = 1'b0;
  logic         Snooze = 1'b0, Stop = 1'b0, Mute = 1'b0;
  logic [2:0]   Sel = 3'd0;
  logic [4:0]   hours;
  logic [5:0]   mins;
  logic [2:0]   day;
  logic [N-1:0] alarm_en;
  logic [2:0]   active_alarm;
  logic         sound, dblink, snoozing;

  int n_cmp = 0;
  int n_bad = 0;

  // Command bit masks for cmd()
  localparam logic [6:0] C_ST = 7'h01, C_SA = 7'h02, C_NX = 7'h04, C_UP = 7'h08;
  localparam logic [6:0] C_SN = 7'h10, C_SP = 7'h20, C_TK = 7'h40;

  alarm_core_multi #(.N_ALARMS(N), .TICKS_PER_MIN(2), .SNOOZE_MIN(2), .RING_MIN(3)) dut (
    .Clk(Clk), .Clr(Clr), .Tick(Tick), .SetTime(SetTime), .SetAlarm(SetAlarm),
    .Next(Next), .Up(Up), .Snooze(Snooze), .Stop(Stop), .Mute(Mute), .Sel(Sel),
    .hours(hours), .mins(mins), .day(day), .alarm_en(alarm_en),
    .active_alarm(active_alarm), .sound(sound), .dblink(dblink), .snoozing(snoozing)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic cmd(input logic [6:0] m);
    {Tick, Stop, Snooze, Up, Next, SetAlarm, SetTime} = m;
    step();
    {Tick, Stop, Snooze, Up, Next, SetAlarm, SetTime} = 7'h00;
  endtask

  task automatic cmd_n(input logic [6:0] m, input int n);
    repeat (n) cmd(m);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".hours"},    32'(hours), 32'd0);
    chk({tag, ".mins"},     32'(mins), 32'd0);
    chk({tag, ".day"},      32'(day), 32'd0);
    chk({tag, ".alarm_en"}, 32'(alarm_en), 32'd0);
    chk({tag, ".active"},   32'(active_alarm), 32'd0);
    chk({tag, ".sound"},    32'(sound), 32'd0);
    chk({tag, ".dblink"},   32'(dblink), 32'd0);
    chk({tag, ".snoozing"}, 32'(snoozing), 32'd0);
  endtask

  initial begin
    step();
    step();
    Clr = 1'b0;
    chk_reset("reset");

    // SetTime and SetAlarm together: SET_TIME wins; set 23:59 day 6
    Sel = 3'd0;
    cmd(C_ST | C_SA);
    chk("edit.dblink", 32'(dblink), 32'd1);
    cmd_n(C_UP, 23);
    cmd(C_NX);
    cmd_n(C_UP, 59);
    cmd(C_NX);
    cmd_n(C_UP, 6);
    cmd_n(C_TK, 3);
    chk("edit.hours", 32'(hours), 32'd23);
    chk("edit.mins_tick_ignored", 32'(mins), 32'd59);
    chk("edit.day", 32'(day), 32'd6);
    chk("edit.no_alarm_touched", 32'(alarm_en), 32'd0);
    cmd(C_ST);
    chk("run.dblink", 32'(dblink), 32'd0);

    // Rollover 23:59 day 6 -> 00:00 day 0
    cmd_n(C_TK, 2);
    chk("roll.hours", 32'(hours), 32'd0);
    chk("roll.mins", 32'(mins), 32'd0);
    chk("roll.day", 32'(day), 32'd0);

    // Alarms 1 and 2 at 00:01, enabled
    Sel = 3'd1;
    cmd(C_SA);
    cmd(C_NX);
    cmd(C_UP);
    chk("al1.mins", 32'(mins), 32'd1);
    cmd(C_NX);
    cmd(C_UP);
    chk("al1.en", 32'(alarm_en), 32'b0010);
    cmd(C_SA);
    chk("al1.back_to_time", 32'(mins), 32'd0);
    Sel = 3'd2;
    cmd(C_SA);
    cmd(C_NX);
    cmd(C_UP);
    cmd(C_NX);
    cmd(C_UP);
    cmd(C_SA);
    chk("al2.en", 32'(alarm_en), 32'b0110);
    Sel = 3'd5;
    cmd(C_SA);
    chk("sel_oob.dblink", 32'(dblink), 32'd0);

    // Advance to 00:01: lowest index rings
    cmd_n(C_TK, 2);
    step();
    step();
    chk("prio.sound", 32'(sound), 32'd1);
    chk("prio.active", 32'(active_alarm), 32'd1);

    // Mute silences without leaving RING
    Mute = 1'b1;
    step();
    step();
    chk("mute.sound", 32'(sound), 32'd0);
    chk("mute.snoozing", 32'(snoozing), 32'd0);
    Mute = 1'b0;
    step();
    chk("unmute.sound", 32'(sound), 32'd1);

    // Snooze for two minute events, then ring again
    cmd(C_SN);
    step();
    chk("snz.snoozing", 32'(snoozing), 32'd1);
    chk("snz.sound", 32'(sound), 32'd0);
    cmd_n(C_TK, 4);
    step();
    chk("snz.still_quiet", 32'(sound), 32'd0);
    step();
    chk("snz.rering", 32'(sound), 32'd1);
    chk("snz.cleared", 32'(snoozing), 32'd0);

    // Ring timeout after three unanswered minutes
    cmd_n(C_TK, 4);
    step();
    step();
    chk("tmo.two_min", 32'(sound), 32'd1);
    cmd_n(C_TK, 2);
    step();
    step();
    chk("tmo.stopped", 32'(sound), 32'd0);

    // Alarm 0 at 00:07; Snooze+Stop together stops
    Sel = 3'd0;
    cmd(C_SA);
    cmd(C_NX);
    cmd_n(C_UP, 7);
    cmd(C_NX);
    cmd(C_UP);
    cmd(C_SA);
    chk("al0.en", 32'(alarm_en), 32'b0111);
    cmd_n(C_TK, 2);
    step();
    step();
    chk("al0.sound", 32'(sound), 32'd1);
    chk("al0.active", 32'(active_alarm), 32'd0);
    cmd(C_SN | C_SP);
    step();
    chk("stopwins.snoozing", 32'(snoozing), 32'd0);
    chk("stopwins.sound", 32'(sound), 32'd0);

    // Alarm 1 moved to 00:08, snoozed, then Clr mid-edit
    Sel = 3'd1;
    cmd(C_SA);
    cmd(C_NX);
    cmd_n(C_UP, 7);
    cmd(C_SA);
    cmd_n(C_TK, 2);
    step();
    step();
    chk("al1b.active", 32'(active_alarm), 32'd1);
    cmd(C_SN);
    step();
    chk("al1b.snoozing", 32'(snoozing), 32'd1);
    Sel = 3'd2;
    cmd(C_SA);
    cmd(C_UP);
    chk("al1b.dblink", 32'(dblink), 32'd1);
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    chk_reset("clr");
    cmd_n(C_TK, 2);
    step();
    step();
    chk("post_clr.mins", 32'(mins), 32'd1);
    chk("post_clr.sound", 32'(sound), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
